// File: rtl/paddle_pot_timer_pkg.sv
// Shared types, widths and threshold arithmetic for the paddle pot timer.
// Optional jitter (macro POT_JITTER_EN) uses the LFSR constants below.
package paddle_pot_pkg;

    localparam int unsigned PADDLE_W = 8;
    localparam int unsigned NUM_POTS = 4;
    localparam int unsigned LFSR_W   = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        POT_DUMPED   = 2'd0,
        POT_CHARGING = 2'd1,
        POT_CHARGED  = 2'd2
    } pot_state_t;

    // Charge threshold in scanlines: MIN_LINES + ((value*SPAN)>>8) + jitter,
    // clamped to the largest value the line counter can hold.
    function automatic int unsigned pot_threshold(
        input logic [PADDLE_W-1:0] value,
        input int unsigned         min_lines,
        input int unsigned         span,
        input int unsigned         cnt_w,
        input logic                jitter = 1'b0
    );
        logic [16:0]  prod;
        int unsigned  thr;
        int unsigned  lim;
        prod = 17'(32'(value) * span);
        thr  = min_lines + 32'(prod >> 8) + 32'(jitter);
        lim  = (32'd1 << cnt_w) - 32'd1;
        return (thr > lim) ? lim : thr;
    endfunction

endpackage

// File: rtl/paddle_pot_timer_if.sv
// Paddle-side bus of the pot timer.
//   hs        TIA horizontal sync level
//   dump      VBLANK D7, grounds all pots when 1
//   paddle_N  8-bit pot positions
//   pot_out   per-pot charged bits (INPT0-3 bit 7)
interface paddle_pot_timer_if;
    import paddle_pot_pkg::*;

    logic                hs;
    logic                dump;
    logic [PADDLE_W-1:0] paddle_1;
    logic [PADDLE_W-1:0] paddle_2;
    logic [PADDLE_W-1:0] paddle_3;
    logic [PADDLE_W-1:0] paddle_4;
    logic [NUM_POTS-1:0] pot_out;

    modport master (
        output hs, dump, paddle_1, paddle_2, paddle_3, paddle_4,
        input  pot_out
    );

    modport slave (
        input  hs, dump, paddle_1, paddle_2, paddle_3, paddle_4,
        output pot_out
    );

endinterface

// File: rtl/paddle_pot_timer_channel.sv
// One pot capacitor: dump / charge / charged sequencing, line counter and
// threshold latch.
//   clk, reset  clock, synchronous active-high reset
//   line_stb    one-cycle pulse per scanline
//   dump        1 discharges the pot
//   value       pot position, sampled when the charge starts
//   jitter      extra line added to the threshold at latch time
//   charged     registered charged flag
module pot_channel
    import paddle_pot_pkg::*;
#(
    parameter int unsigned MIN_LINES = 2,
    parameter int unsigned SPAN      = 380,
    parameter int unsigned CNT_W     = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                line_stb,
    input  logic                dump,
    input  logic [PADDLE_W-1:0] value,
    input  logic                jitter,
    output logic                charged
);

    localparam logic [1:0] S_DUMPED   = 2'(POT_DUMPED);
    localparam logic [1:0] S_CHARGING = 2'(POT_CHARGING);
    localparam logic [1:0] S_CHARGED  = 2'(POT_CHARGED);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [CNT_W-1:0] thr_q, thr_n;
    logic             out_q, out_n;
    logic [CNT_W:0]   cnt_inc;

    // State, counter, threshold and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_DUMPED;
            cnt_q   <= '0;
            thr_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            thr_q   <= thr_n;
            out_q   <= out_n;
        end
    end

    // Extra bit so the comparison sees cnt+1 even at the counter ceiling.
    assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

    // Next-state and next-output logic; dump wins over any strobe.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        thr_n   = thr_q;
        out_n   = out_q;
        case (state_q)
            S_DUMPED: begin
                cnt_n = '0;
                out_n = 1'b0;
                if (!dump) begin
                    thr_n   = CNT_W'(pot_threshold(value, MIN_LINES, SPAN, CNT_W, jitter));
                    state_n = S_CHARGING;
                end
            end
            S_CHARGING: begin
                if (dump) begin
                    cnt_n   = '0;
                    out_n   = 1'b0;
                    state_n = S_DUMPED;
                end else if (thr_q == '0) begin
                    out_n   = 1'b1;
                    state_n = S_CHARGED;
                end else if (line_stb) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                    if (cnt_inc >= {1'b0, thr_q}) begin
                        out_n   = 1'b1;
                        state_n = S_CHARGED;
                    end
                end
            end
            S_CHARGED: begin
                if (dump) begin
                    cnt_n   = '0;
                    out_n   = 1'b0;
                    state_n = S_DUMPED;
                end else begin
                    out_n = 1'b1;
                end
            end
            default: begin
                cnt_n   = '0;
                out_n   = 1'b0;
                state_n = S_DUMPED;
            end
        endcase
    end

    assign charged = out_q;

endmodule

// File: rtl/paddle_pot_timer.sv
// TIA paddle potentiometer emulation: four independent pot channels timed
// in scanlines from the rising edge of hs.
//   clk, reset  clock, synchronous active-high reset
//   bus         paddle_pot_timer_if.slave (hs, dump, paddle_1..4, pot_out)
// Build option: define POT_JITTER_EN to add one LFSR bit of charge noise
// per channel at threshold latch.
module paddle_pot_timer
    import paddle_pot_pkg::*;
#(
    parameter int unsigned MIN_LINES = 2,
    parameter int unsigned SPAN      = 380,
    parameter int unsigned CNT_W     = 9
) (
    input  logic               clk,
    input  logic               reset,
    paddle_pot_timer_if.slave  bus
);

    logic hs_d;
    logic run_q;
    logic line_stb;

    // hs edge register; run_q masks the first cycle after reset so an hs
    // that is already high at release is not taken as a new line.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_d  <= 1'b0;
            run_q <= 1'b0;
        end else begin
            hs_d  <= bus.hs;
            run_q <= 1'b1;
        end
    end

    assign line_stb = bus.hs & ~hs_d & run_q;

    logic [NUM_POTS-1:0] jitter;

`ifdef POT_JITTER_EN
    logic [LFSR_W-1:0] lfsr_q;

    // Galois LFSR stepped once per scanline.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (line_stb) begin
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        end
    end

    assign jitter = lfsr_q[NUM_POTS-1:0];
`else
    assign jitter = '0;
`endif

    logic [PADDLE_W-1:0] value [NUM_POTS];
    logic [NUM_POTS-1:0] charged;

    assign value[0] = bus.paddle_1;
    assign value[1] = bus.paddle_2;
    assign value[2] = bus.paddle_3;
    assign value[3] = bus.paddle_4;

    for (genvar n = 0; n < NUM_POTS; n++) begin : g_pot
        pot_channel #(
            .MIN_LINES (MIN_LINES),
            .SPAN      (SPAN),
            .CNT_W     (CNT_W)
        ) u_pot (
            .clk      (clk),
            .reset    (reset),
            .line_stb (line_stb),
            .dump     (bus.dump),
            .value    (value[n]),
            .jitter   (jitter[n]),
            .charged  (charged[n])
        );
    end

    // Each bit comes straight from a channel output register.
    assign bus.pot_out = charged;

endmodule

// File: tb/tb_paddle_pot_timer.sv
`timescale 1ns/1ps
module tb_paddle_pot_timer;

    logic clk = 1'b0;
    logic reset;

    paddle_pot_timer_if bus();

    paddle_pot_timer #(
        .MIN_LINES (2),
        .SPAN      (380),
        .CNT_W     (9)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 1'b0;

    // Reference: per pot, whether the capacitor is free to charge, how many
    // scanlines it has seen since then (unbounded), and its threshold.
    bit          m_hs_prev;
    bit          m_run;
    bit          m_active [4];
    int          m_lines  [4];
    int          m_thr    [4];
    logic [3:0]  m_out;
    logic [15:0] m_lfsr;
    bit          m_stb;
    int          m_jit;
    logic [7:0]  m_pv [4];

    function automatic int ref_thr(input int v, input int jit);
        int t;
        t = 2 + (v * 380) / 256 + jit;
        if (t > 511) t = 511;
        return t;
    endfunction

    always @(posedge clk) begin
        m_pv[0] = bus.paddle_1;
        m_pv[1] = bus.paddle_2;
        m_pv[2] = bus.paddle_3;
        m_pv[3] = bus.paddle_4;
        m_stb = (bus.hs === 1'b1) && !m_hs_prev && m_run;
        if (reset) begin
            m_hs_prev = 1'b0;
            m_run     = 1'b0;
            m_out     = 4'b0;
            m_lfsr    = 16'hACE1;
            for (int ch = 0; ch < 4; ch++) begin
                m_active[ch] = 1'b0;
                m_lines[ch]  = 0;
                m_thr[ch]    = 0;
            end
        end else begin
            for (int ch = 0; ch < 4; ch++) begin
                if (bus.dump) begin
                    m_active[ch] = 1'b0;
                    m_lines[ch]  = 0;
                    m_out[ch]    = 1'b0;
                end else if (!m_active[ch]) begin
                    m_jit = 0;
`ifdef POT_JITTER_EN
                    m_jit = int'(m_lfsr[ch]);
`endif
                    m_active[ch] = 1'b1;
                    m_lines[ch]  = 0;
                    m_out[ch]    = 1'b0;
                    m_thr[ch]    = ref_thr(int'(m_pv[ch]), m_jit);
                end else begin
                    if (m_stb) m_lines[ch]++;
                    m_out[ch] = (m_lines[ch] >= m_thr[ch]);
                end
            end
            if (m_stb) m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            m_hs_prev = bus.hs;
            m_run     = 1'b1;
        end
    end

    // Every-cycle comparison against the reference.
    always @(negedge clk) begin
        if (chk_en) begin
            compared++;
            if (bus.pot_out !== m_out) begin
                mismatched++;
                $display("FAIL pot_out_cycle t=%0t: got %b need %b", $time, bus.pot_out, m_out);
            end
        end
    end

    task automatic check(input string name, input int got, input int need);
        compared++;
        if (got !== need) begin
            mismatched++;
            $display("FAIL %s: got %0d need %0d", name, got, need);
        end
    endtask

    task automatic check_rise(input string name, input int got, input int thr);
`ifdef POT_JITTER_EN
        compared++;
        if (got != thr && got != thr + 1) begin
            mismatched++;
            $display("FAIL %s: got %0d need %0d or %0d", name, got, thr, thr + 1);
        end
`else
        check(name, got, thr);
`endif
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic line();
        bus.hs = 1'b1;
        cyc(2);
        bus.hs = 1'b0;
        cyc(2);
    endtask

    // Lines until each pot charges; -1 if it never does within max_lines.
    task automatic measure(input int max_lines, output int rise [4]);
        for (int ch = 0; ch < 4; ch++) rise[ch] = -1;
        for (int i = 1; i <= max_lines; i++) begin
            line();
            for (int ch = 0; ch < 4; ch++)
                if (rise[ch] < 0 && bus.pot_out[ch] === 1'b1) rise[ch] = i;
        end
    endtask

    task automatic dump_cycle();
        bus.dump = 1'b1;
        cyc(2);
        bus.dump = 1'b0;
        cyc(1);
    endtask

    int rise [4];

    initial begin
        reset        = 1'b1;
        bus.hs       = 1'b0;
        bus.dump     = 1'b0;
        bus.paddle_1 = 8'd0;
        bus.paddle_2 = 8'd0;
        bus.paddle_3 = 8'd0;
        bus.paddle_4 = 8'd0;
        cyc(1);
        chk_en = 1'b1;

        // Reset held while hs toggles: nothing charges.
        repeat (3) line();
        check("reset_pot_out", int'(bus.pot_out), 0);

        // Release with hs high, then count lines at position 0.
        bus.hs = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(2);
        bus.hs = 1'b0;
        cyc(1);
        measure(10, rise);
        check_rise("rise_after_reset_p0", rise[0], 2);

        // Mid-scale pot: 191 lines not enough, 192nd charges.
        bus.paddle_1 = 8'd128;
        dump_cycle();
        repeat (191) line();
`ifndef POT_JITTER_EN
        check("p128_at_191", int'(bus.pot_out[0]), 0);
`endif
        line();
`ifndef POT_JITTER_EN
        check("p128_at_192", int'(bus.pot_out[0]), 1);
`endif

        // Four pots at distinct positions, each on its own schedule.
        bus.paddle_1 = 8'd0;
        bus.paddle_2 = 8'd64;
        bus.paddle_3 = 8'd192;
        bus.paddle_4 = 8'd255;
        dump_cycle();
        measure(400, rise);
        check_rise("rise_p0",   rise[0], 2);
        check_rise("rise_p64",  rise[1], 97);
        check_rise("rise_p192", rise[2], 287);
        check_rise("rise_p255", rise[3], 380);

        // Dump mid-charge discards progress; recharge needs the full count.
        bus.paddle_1 = 8'd255;
        dump_cycle();
        repeat (100) line();
        bus.dump = 1'b1;
        cyc(1);
        check("dump_mid_charge", int'(bus.pot_out[0]), 0);
        cyc(3);
        bus.dump = 1'b0;
        cyc(1);
        measure(400, rise);
        check_rise("recharge_p255", rise[0], 380);

        // Dump and a line strobe together while charged: dump wins.
        bus.paddle_1 = 8'd0;
        dump_cycle();
        repeat (3) line();
        check("charged_before_dump", int'(bus.pot_out[0]), 1);
        bus.dump = 1'b1;
        bus.hs   = 1'b1;
        cyc(1);
        check("dump_with_stb", int'(bus.pot_out[0]), 0);
        bus.hs = 1'b0;
        cyc(1);

        // Paddle change after latch is ignored.
        bus.dump = 1'b0;
        cyc(1);
        line();
        check("latch_line1", int'(bus.pot_out[0]), 0);
        bus.paddle_1 = 8'd255;
        line();
`ifndef POT_JITTER_EN
        check("latch_line2", int'(bus.pot_out[0]), 1);
`endif

        // Randomized traffic checked every cycle against the reference.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 2) == 0) bus.hs = ~bus.hs;
            if (bus.dump) begin
                if ($urandom_range(0, 3) == 0) bus.dump = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                bus.dump = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) begin
                case ($urandom_range(0, 3))
                    0: bus.paddle_1 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
                    1: bus.paddle_2 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
                    2: bus.paddle_3 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
                    default: bus.paddle_4 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
                endcase
            end
            reset = ($urandom_range(0, 1999) == 0);
            cyc(1);
        end
        reset = 1'b0;
        cyc(2);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/paddle_pot_timer.md
Name: paddle_pot_timer

Overview:
- Emulates the four TIA paddle potentiometer/capacitor inputs (INPT0-INPT3 bit 7).
- Sits directly downstream of the paddle controllers: consumes their 8-bit analog positions (paddle_1..paddle_4, post-swap/invert) and produces per-pot "charged" bits for the TIA input port.
- Charge time is counted in scanlines from the TIA horizontal sync, so readings stay consistent across NTSC and PAL timing.

Parameters:
- MIN_LINES, 2, scanlines to charge at position 0.
- SPAN, 380, extra scanlines at full scale. Threshold = MIN_LINES + ((value*SPAN)>>8).
- CNT_W, 9, line counter width. The counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- hs  in  1  TIA horizontal sync level; the rising edge marks one scanline
- dump  in  1  TIA VBLANK D7; 1 grounds all pots (capacitors discharged)
- paddle_1  in  8  pot 0 position (0 = minimum resistance)
- paddle_2  in  8  pot 1 position
- paddle_3  in  8  pot 2 position
- paddle_4  in  8  pot 3 position
- pot_out  out  4  bit n = 1 when pot n is charged (INPT n, bit 7)

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high. On reset: pot_out=0, all channels DUMPED, counters=0, hs edge register=0.
- Line strobe: line_stb = hs & ~hs_d, where hs_d is hs registered on clk. Exactly one cycle per rising edge. hs high at reset release does not generate a strobe.
- Per-channel FSM (identical, independent):
  - DUMPED: cnt=0, out=0. When dump=0, latch thr from the current paddle value and go to CHARGING.
  - CHARGING: each line_stb increments cnt (saturating). When cnt+1 >= thr on a strobe cycle, set out=1 and go to CHARGED. dump=1 goes to DUMPED.
  - CHARGED: out=1 and cnt frozen. dump=1 goes to DUMPED.
- Latency:
  - The channel reaches out=1 on the clock edge that registers the thr-th line_stb after dump is released.
  - If thr=0, out=1 one cycle after entering CHARGING.
- Dump priority:
  - dump=1 in any state forces DUMPED. out falls on the next clock edge, even if line_stb is asserted in the same cycle.
  - dump re-asserted mid-charge discards the count; the next release starts from 0.
- Threshold arithmetic:
  - Unsigned product value*SPAN, 17 bits, then >>8, then +MIN_LINES.
  - Clamp to 2^CNT_W-1.
  - thr is latched only on the DUMPED→CHARGING transition; paddle changes during a charge are ignored.
- Saturation: cnt never wraps. If thr equals the clamp value, the channel still charges when cnt reaches it.
- Outputs: pot_out is fully registered, with no combinational path from inputs.

Optional Feature:
- Macro: POT_JITTER_EN.
- When defined:
  - A 16-bit Galois LFSR (taps 0xB400, seed 0xACE1 on reset) advances on each line_stb.
  - On latch, channel n adds LFSR bit n (0 or 1) to thr before the clamp, modelling analog charge noise.
- When undefined: no LFSR is instantiated and thresholds are fully deterministic.

Decomposition:
- Package paddle_pot_pkg holds:
  - typedef pot_state_t {POT_DUMPED, POT_CHARGING, POT_CHARGED};
  - localparam function pot_threshold(value, MIN_LINES, SPAN, CNT_W) with the clamp.
- Sub-module pot_channel: FSM, counter, threshold latch. It is instantiated 4 times. Edge detect and LFSR stay in the top.

Test Plan:
- Reset with dump=0, hs toggling → pot_out=0 during reset. After release, with paddle_1=0, pot_out[0]=1 after the 2nd hs rising edge.
- paddle_1=128, dump 1→0, then 191 line strobes → pot_out[0]=0. On the 192nd strobe → pot_out[0]=1 one clock later.
- All four paddles at 0, 64, 192, 255 → bits rise after 2, 97, 287 and 380 strobes respectively, each independently.
- paddle_1=255, dump re-asserted after 100 lines, then released → pot_out[0]=0 within 1 clock and stays 0. Recharge needs a full 380 lines from 0.
- dump=1 and line_stb in the same cycle while CHARGED → pot_out drops next clock. Changing paddle_1 from 0 to 255 mid-charge → still charges at line 2.
- With POT_JITTER_EN: each charge time lies in {thr, thr+1}, and the sequence repeats identically after reset.
